sha256_round_core: RTL

//  SHA-256 compression engine, directly upstream of the H0..H7 hash-accumulate stages.

---
 rtl/sha256_round_core_if.sv | 35 +++
 rtl/sha256_round_core.sv | 110 +++++++++++
 2 files changed

// File: rtl/sha256_round_core_if.sv
// Purpose: bundles the control, data and status signals of the SHA-256 round core.
// Latency: none, wiring only.
// Backpressure: w_valid/w_ready handshake on the schedule-word input.
interface sha256_round_core_if;
    logic         start;
    logic [255:0] h_in;
    logic [31:0]  w_in;
    logic         w_valid;
    logic         w_ready;
    logic [31:0]  a_out;
    logic [31:0]  b_out;
    logic [31:0]  c_out;
    logic [31:0]  d_out;
    logic [31:0]  e_out;
    logic [31:0]  f_out;
    logic [31:0]  g_out;
    logic [31:0]  h_out;
    logic [5:0]   round;
    logic         busy;
    logic         done;

    // Driver side: the block feeding h_in and the message schedule.
    modport master (
        output start, h_in, w_in, w_valid,
        input  w_ready, a_out, b_out, c_out, d_out, e_out, f_out, g_out, h_out,
               round, busy, done
    );

    // Core side.
    modport slave (
        input  start, h_in, w_in, w_valid,
        output w_ready, a_out, b_out, c_out, d_out, e_out, f_out, g_out, h_out,
               round, busy, done
    );
endinterface

// File: rtl/sha256_round_core.sv
// Purpose: SHA-256 compression rounds; loads a..h from h_in, runs one round per accepted W word.
// Latency: 1 load cycle + one cycle per beat (64 beats) + 1 DONE cycle.
// Backpressure: w_ready is high only in RUN; a low w_valid stalls the round with no state change.
module sha256_round_core #(
    parameter int NROUNDS = 64
) (
    input  logic                 clk,
    input  logic                 rst_n,
    sha256_round_core_if.slave   ifc
);
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [31:0] K [0:63] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    localparam logic [5:0] LAST_ROUND = 6'(NROUNDS - 1);

    state_t      state_q, state_d;
    logic [31:0] a_q, b_q, c_q, d_q, e_q, f_q, g_q, h_q;
    logic [31:0] a_d, b_d, c_d, d_d, e_d, f_d, g_d, h_d;
    logic [5:0]  round_q, round_d;
    logic [31:0] t1, t2;
    logic        beat;

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    // Status and handshake come straight from the state register.
    assign ifc.w_ready = (state_q == ST_RUN);
    assign ifc.busy    = (state_q == ST_RUN);
    assign ifc.done    = (state_q == ST_DONE);
    assign ifc.round   = round_q;
    assign ifc.a_out   = a_q;
    assign ifc.b_out   = b_q;
    assign ifc.c_out   = c_q;
    assign ifc.d_out   = d_q;
    assign ifc.e_out   = e_q;
    assign ifc.f_out   = f_q;
    assign ifc.g_out   = g_q;
    assign ifc.h_out   = h_q;
    assign beat        = ifc.w_valid && (state_q == ST_RUN);

    // Round datapath plus next-state: load in IDLE, shift/compress on beats in RUN, hold otherwise.
    always_comb begin
        state_d = state_q;
        round_d = round_q;
        a_d = a_q; b_d = b_q; c_d = c_q; d_d = d_q;
        e_d = e_q; f_d = f_q; g_d = g_q; h_d = h_q;
        t1 = h_q + (rotr(e_q, 6) ^ rotr(e_q, 11) ^ rotr(e_q, 25))
                 + ((e_q & f_q) ^ (~e_q & g_q)) + K[round_q] + ifc.w_in;
        t2 = (rotr(a_q, 2) ^ rotr(a_q, 13) ^ rotr(a_q, 22))
                 + ((a_q & b_q) ^ (a_q & c_q) ^ (b_q & c_q));
        case (state_q)
            ST_IDLE: begin
                if (ifc.start) begin
                    {a_d, b_d, c_d, d_d, e_d, f_d, g_d, h_d} = ifc.h_in;
                    round_d = 6'd0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (beat) begin
                    h_d = g_q;
                    g_d = f_q;
                    f_d = e_q;
                    e_d = d_q + t1;
                    d_d = c_q;
                    c_d = b_q;
                    b_d = a_q;
                    a_d = t1 + t2;
                    round_d = round_q + 6'd1;
                    if (round_q == LAST_ROUND) begin
                        round_d = 6'd0;
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // State, round counter and working variables; async reset clears everything.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            round_q <= 6'd0;
            a_q <= '0; b_q <= '0; c_q <= '0; d_q <= '0;
            e_q <= '0; f_q <= '0; g_q <= '0; h_q <= '0;
        end else begin
            state_q <= state_d;
            round_q <= round_d;
            a_q <= a_d; b_q <= b_d; c_q <= c_d; d_q <= d_d;
            e_q <= e_d; f_q <= f_d; g_q <= g_d; h_q <= h_d;
        end
    end
endmodule
